// File: rtl/wave_period_meter.sv
// Measures clock cycles between successive rising edges of an asynchronous square wave
// and presents each period on a registered valid/ready output.
module wave_period_meter #(
    parameter int width_p       = 16,
    parameter int sync_stages_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               wave_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [width_p-1:0] period_o,
    output logic               overflow_o,
    output logic               missed_o,
    output logic [1:0]         state_o
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;

    localparam logic [width_p-1:0] fill_c = width_p'(sync_stages_p);
    localparam logic [width_p-1:0] one_c  = width_p'(1);
    localparam logic [width_p-1:0] max_c  = '1;

    logic [sync_stages_p-1:0] sync_q;
    logic                     prev_q;
    logic                     s;
    logic                     rise;

    logic [1:0]         state_q;
    logic [width_p-1:0] cnt_q;
    logic               sat_q;
    logic               cap_q;
    logic [width_p-1:0] cap_period_q;
    logic               cap_ovf_q;

    assign s       = sync_q[sync_stages_p-1];
    assign rise    = s & ~prev_q;
    assign state_o = state_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[sync_stages_p-2:0], wave_i};
            prev_q <= s;
        end
    end

    // In IDLE the counter first waits for the synchronizer to flush, so a wave
    // already high at reset release is seen as high and never mistaken for a rise.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sat_q        <= 1'b0;
            cap_q        <= 1'b0;
            cap_period_q <= '0;
            cap_ovf_q    <= 1'b0;
        end else begin
            cap_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cnt_q < fill_c) begin
                        cnt_q <= cnt_q + one_c;
                    end else if (!s) begin
                        state_q <= ARMED;
                        cnt_q   <= '0;
                    end
                end
                ARMED: begin
                    if (rise) begin
                        state_q <= MEASURE;
                        cnt_q   <= one_c;
                        sat_q   <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        cap_q        <= 1'b1;
                        cap_period_q <= cnt_q;
                        cap_ovf_q    <= sat_q;
                        cnt_q        <= one_c;
                        sat_q        <= 1'b0;
                    end else if (cnt_q == max_c) begin
                        sat_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + one_c;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Handshake: a measurement transfers on a cycle with valid_o & ready_i; valid_o
    // and the data are registered and held while ready_i is low, and ready_i is ignored
    // while valid_o is low. A capture arriving while the held value is unaccepted is
    // dropped and flagged on missed_o.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_o    <= 1'b0;
            period_o   <= '0;
            overflow_o <= 1'b0;
            missed_o   <= 1'b0;
        end else begin
            missed_o <= 1'b0;
            if (cap_q) begin
                if (!valid_o || ready_i) begin
                    valid_o    <= 1'b1;
                    period_o   <= cap_period_q;
                    overflow_o <= cap_ovf_q;
                end else begin
                    missed_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wave_period_meter.sv
// Directed bench for wave_period_meter: a 16-bit and a 4-bit instance share stimulus,
// and every output is checked against hand-derived cycle-by-cycle expectations.
module tb_wave_period_meter;

    logic        clk;
    logic        reset_i;
    logic        wave_i;
    logic        ready_i;

    logic        valid;
    logic [15:0] period;
    logic        overflow;
    logic        missed;
    logic [1:0]  state;

    logic        valid4;
    logic [3:0]  period4;
    logic        overflow4;
    logic        missed4;
    logic [1:0]  state4;

    int total = 0;
    int bad   = 0;

    wave_period_meter #(.width_p(16), .sync_stages_p(2)) dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .wave_i    (wave_i),
        .ready_i   (ready_i),
        .valid_o   (valid),
        .period_o  (period),
        .overflow_o(overflow),
        .missed_o  (missed),
        .state_o   (state)
    );

    wave_period_meter #(.width_p(4), .sync_stages_p(2)) dut4 (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .wave_i    (wave_i),
        .ready_i   (ready_i),
        .valid_o   (valid4),
        .period_o  (period4),
        .overflow_o(overflow4),
        .missed_o  (missed4),
        .state_o   (state4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    // Holds reset for two edges with the current wave level, checks reset values, releases.
    task automatic do_reset(input logic w, input logic r);
        wave_i  = w;
        ready_i = r;
        reset_i = 1'b1;
        tick();
        tick();
        chk("rst_valid", 0, 32'(valid), 32'd0);
        chk("rst_period", 0, 32'(period), 32'd0);
        chk("rst_overflow", 0, 32'(overflow), 32'd0);
        chk("rst_missed", 0, 32'(missed), 32'd0);
        chk("rst_state", 0, 32'(state), 32'd0);
        chk("rst_valid4", 0, 32'(valid4), 32'd0);
        reset_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        wave_i  = 1'b0;
        ready_i = 1'b0;

        // Test 1: rises every 7 cycles from 20, ready held high.
        do_reset(1'b0, 1'b1);
        for (int t = 1; t <= 40; t++) begin
            wave_i  = (t >= 20) && (t < 37) && (((t - 20) % 7) < 3);
            ready_i = 1'b1;
            tick();
            chk("t1_valid", t, 32'(valid), 32'(t == 30 || t == 37));
            chk("t1_missed", t, 32'(missed), 32'd0);
            if (t == 30 || t == 37) begin
                chk("t1_period", t, 32'(period), 32'd7);
                chk("t1_overflow", t, 32'(overflow), 32'd0);
            end
            if (t == 10) chk("t1_state_armed", t, 32'(state), 32'd1);
            if (t == 22) chk("t1_state_measure", t, 32'(state), 32'd2);
        end

        // Test 2: wave high through reset release, falls at 10, rises at 15 and 25.
        do_reset(1'b1, 1'b1);
        for (int t = 1; t <= 32; t++) begin
            wave_i  = (t < 10) || (t >= 15 && t < 18) || (t >= 25 && t < 28);
            ready_i = 1'b1;
            tick();
            chk("t2_valid", t, 32'(valid), 32'(t == 28));
            if (t == 28) chk("t2_period", t, 32'(period), 32'd10);
            if (t == 5)  chk("t2_state_idle", t, 32'(state), 32'd0);
            if (t == 13) chk("t2_state_armed", t, 32'(state), 32'd1);
        end

        // Test 3: backpressure, rises every 5 cycles from 20, ready only at 50.
        do_reset(1'b0, 1'b0);
        for (int t = 1; t <= 60; t++) begin
            wave_i  = (t >= 20) && (((t - 20) % 5) < 2);
            ready_i = (t == 50);
            tick();
            chk("t3_valid", t, 32'(valid), 32'((t >= 28 && t <= 49) || t >= 53));
            chk("t3_missed", t, 32'(missed),
                32'(t == 33 || t == 38 || t == 43 || t == 48 || t == 58));
            if ((t >= 28 && t <= 49) || t >= 53) chk("t3_period", t, 32'(period), 32'd5);
        end

        // Test 4: saturation on the 4-bit instance, then 10 and exactly 15 cycles.
        do_reset(1'b0, 1'b1);
        for (int t = 1; t <= 72; t++) begin
            wave_i  = (t >= 20 && t < 23) || (t >= 40 && t < 43) ||
                      (t >= 50 && t < 53) || (t >= 65 && t < 68);
            ready_i = 1'b1;
            tick();
            chk("t4_valid4", t, 32'(valid4), 32'(t == 43 || t == 53 || t == 68));
            chk("t4_valid16", t, 32'(valid), 32'(t == 43 || t == 53 || t == 68));
            if (t == 43) begin
                chk("t4_sat_period4", t, 32'(period4), 32'd15);
                chk("t4_sat_overflow4", t, 32'(overflow4), 32'd1);
                chk("t4_period16", t, 32'(period), 32'd20);
                chk("t4_overflow16", t, 32'(overflow), 32'd0);
            end
            if (t == 53) begin
                chk("t4_p10_period4", t, 32'(period4), 32'd10);
                chk("t4_p10_overflow4", t, 32'(overflow4), 32'd0);
            end
            if (t == 68) begin
                chk("t4_max_period4", t, 32'(period4), 32'd15);
                chk("t4_max_overflow4", t, 32'(overflow4), 32'd0);
                chk("t4_max_period16", t, 32'(period), 32'd15);
            end
        end

        // Test 5: capture lands in the one cycle where valid & ready transfers.
        do_reset(1'b0, 1'b0);
        for (int t = 1; t <= 40; t++) begin
            wave_i  = (t >= 20 && t < 22) || (t >= 25 && t < 27) || (t >= 32 && t < 34);
            ready_i = (t == 35);
            tick();
            chk("t5_valid", t, 32'(valid), 32'(t >= 28));
            chk("t5_missed", t, 32'(missed), 32'd0);
            if (t >= 28) chk("t5_period", t, 32'(period), (t < 35) ? 32'd5 : 32'd7);
        end

        // Test 6: reset pulse at 24 mid-measurement; rises continue every 7 cycles.
        do_reset(1'b0, 1'b1);
        for (int t = 1; t <= 40; t++) begin
            wave_i  = (t >= 20) && (((t - 20) % 7) < 3);
            ready_i = 1'b1;
            reset_i = (t == 24);
            tick();
            chk("t6_valid", t, 32'(valid), 32'(t == 37));
            if (t == 24) chk("t6_state_reset", t, 32'(state), 32'd0);
            if (t == 37) chk("t6_period", t, 32'(period), 32'd7);
        end
        reset_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
